// File: rtl/mem_map_pkg.sv
// Shared MMIO register map, STATUS bit layout and byte-lane helper for mem_responder.
package mem_map_pkg;

    localparam logic [7:0] OFF_CONSOLE     = 8'h00;
    localparam logic [7:0] OFF_STATUS      = 8'h04;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h08;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h0C;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h10;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h14;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_CNT_LSB   = 4;

    // Replace the strobed byte lanes of old_w with those of new_w.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count,
    output logic [Width-1:0] head
);

    logic [Width-1:0] mem_r [Depth];
    logic [PtrW-1:0]  wr_ptr_r;
    logic [PtrW-1:0]  rd_ptr_r;
    logic [CntW-1:0]  count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;
    logic             empty_s;

    assign full_s    = (count_r == CntW'(Depth));
    assign empty_s   = (count_r == {CntW{1'b0}});
    assign do_pop_s  = pop & ~empty_s;
    assign do_push_s = push & (~full_s | do_pop_s);

    // Pointer and occupancy state; pointers wrap naturally at Depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PtrW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Data storage is not reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/mem_responder.sv
// Word RAM plus MMIO block (console FIFO, 64-bit timer) answering the core's I and D ports.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int          MemWords  = 16384,
    parameter logic [31:0] MmioBase  = 32'h8000_0000,
    parameter int          FifoDepth = 8,
    parameter string       InitFile  = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq,
    output logic        decode_err
);

    localparam int RamAw = $clog2(MemWords);
    localparam int CntW  = $clog2(FifoDepth) + 1;

    logic [31:0]      mem_r [MemWords];
    logic             i_ram_hit_s;
    logic             d_ram_hit_s;
    logic             d_mmio_hit_s;
    logic [RamAw-1:0] d_idx_s;
    logic [7:0]       d_off_s;
    logic             store_s;
    logic [31:0]      i_data_s;
    logic [31:0]      d_rdata_s;
    logic [31:0]      status_s;

    logic             fifo_push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CntW-1:0]  fifo_count_s;
    logic [7:0]       fifo_head_s;
    logic             pop_fire_s;
    logic             ovf_clr_s;
    logic             overflow_next_s;

    logic [63:0]      mtime_r;
    logic [63:0]      mtimecmp_r;
    logic [63:0]      mtime_next_s;
    logic [63:0]      mtimecmp_next_s;
    logic             overflow_r;
    logic             timer_irq_r;
    logic             decode_err_r;

    assign i_ram_hit_s  = ((i_addr >> (RamAw + 2)) == 32'd0);
    assign d_ram_hit_s  = ((d_addr >> (RamAw + 2)) == 32'd0);
    assign d_mmio_hit_s = (d_addr[31:8] == MmioBase[31:8]);
    assign d_idx_s      = d_addr[RamAw+1:2];
    assign d_off_s      = {d_addr[7:2], 2'b00};
    assign store_s      = (d_wstrb != 4'b0000);
    assign pop_fire_s   = tx_ready & ~fifo_empty_s;

    // Byte-strobed RAM write; reads elsewhere see the old word until the next cycle.
    always_ff @(posedge clk) begin
        if (store_s && d_ram_hit_s) begin
            mem_r[d_idx_s] <= byte_merge(mem_r[d_idx_s], d_wdata, d_wstrb);
        end
    end

    // Instruction fetch read.
    always_comb begin
        i_data_s = 32'd0;
        if (i_ram_hit_s) begin
            i_data_s = mem_r[i_addr[RamAw+1:2]];
        end else begin
            i_data_s = 32'd0;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s                          = 32'd0;
        status_s[STATUS_FULL_BIT]         = fifo_full_s;
        status_s[STATUS_EMPTY_BIT]        = fifo_empty_s;
        status_s[STATUS_OVF_BIT]          = overflow_r;
        status_s[STATUS_CNT_LSB +: 4]     = 4'(fifo_count_s);
    end

    // Data-port read mux over RAM and MMIO.
    always_comb begin
        d_rdata_s = 32'd0;
        if (d_ram_hit_s) begin
            d_rdata_s = mem_r[d_idx_s];
        end else if (d_mmio_hit_s) begin
            case (d_off_s)
                OFF_STATUS:      d_rdata_s = status_s;
                OFF_MTIME_LO:    d_rdata_s = mtime_r[31:0];
                OFF_MTIME_HI:    d_rdata_s = mtime_r[63:32];
                OFF_MTIMECMP_LO: d_rdata_s = mtimecmp_r[31:0];
                OFF_MTIMECMP_HI: d_rdata_s = mtimecmp_r[63:32];
                default:         d_rdata_s = 32'd0;
            endcase
        end else begin
            d_rdata_s = 32'd0;
        end
    end

    // MMIO store decode and next-state for timer, console push and overflow.
    always_comb begin
        mtime_next_s    = mtime_r + 64'd1;
        mtimecmp_next_s = mtimecmp_r;
        fifo_push_s     = 1'b0;
        ovf_clr_s       = 1'b0;
        if (store_s && d_mmio_hit_s) begin
            case (d_off_s)
                OFF_CONSOLE:     fifo_push_s = d_wstrb[0];
                OFF_STATUS:      ovf_clr_s   = d_wstrb[0] & d_wdata[STATUS_OVF_BIT];
                // A timer write suppresses the increment for the whole 64-bit register.
                OFF_MTIME_LO:    mtime_next_s = {mtime_r[63:32], byte_merge(mtime_r[31:0], d_wdata, d_wstrb)};
                OFF_MTIME_HI:    mtime_next_s = {byte_merge(mtime_r[63:32], d_wdata, d_wstrb), mtime_r[31:0]};
                OFF_MTIMECMP_LO: mtimecmp_next_s = {mtimecmp_r[63:32], byte_merge(mtimecmp_r[31:0], d_wdata, d_wstrb)};
                OFF_MTIMECMP_HI: mtimecmp_next_s = {byte_merge(mtimecmp_r[63:32], d_wdata, d_wstrb), mtimecmp_r[31:0]};
                default:         fifo_push_s = 1'b0;
            endcase
        end else begin
            fifo_push_s = 1'b0;
        end
        overflow_next_s = overflow_r;
        if (fifo_push_s && fifo_full_s && !pop_fire_s) begin
            overflow_next_s = 1'b1;
        end else if (ovf_clr_s) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // MMIO state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_r      <= 64'd0;
            mtimecmp_r   <= 64'hFFFF_FFFF_FFFF_FFFF;
            overflow_r   <= 1'b0;
            timer_irq_r  <= 1'b0;
            decode_err_r <= 1'b0;
        end else begin
            mtime_r      <= mtime_next_s;
            mtimecmp_r   <= mtimecmp_next_s;
            overflow_r   <= overflow_next_s;
            timer_irq_r  <= (mtime_next_s >= mtimecmp_next_s);
            decode_err_r <= store_s & ~d_ram_hit_s & ~d_mmio_hit_s;
        end
    end

    sync_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_console_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push_s),
        .push_data (d_wdata[7:0]),
        .pop       (tx_ready),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    assign i_data     = i_data_s;
    assign d_rdata    = d_rdata_s;
    assign tx_data    = fifo_head_s;
    assign tx_valid   = ~fifo_empty_s;
    assign timer_irq  = timer_irq_r;
    assign decode_err = decode_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM vector table plus FIFO, timer, decode and reset sequences.
module tb_mem_responder;

    localparam logic [31:0] A_CONS   = 32'h8000_0000;
    localparam logic [31:0] A_STAT   = 32'h8000_0004;
    localparam logic [31:0] A_MT_LO  = 32'h8000_0008;
    localparam logic [31:0] A_MT_HI  = 32'h8000_000C;
    localparam logic [31:0] A_CMP_LO = 32'h8000_0010;
    localparam logic [31:0] A_CMP_HI = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_data;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_wstrb = 4'b0000;
    logic [31:0] d_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        timer_irq;
    logic        decode_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_d;
        logic [31:0] exp_i;
    } vec_t;

    vec_t tbl[10];

    mem_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_rdata    (d_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .timer_irq  (timer_irq),
        .decode_err (decode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        d_addr  = a;
        d_wdata = d;
        d_wstrb = s;
        cycle();
        d_wstrb = 4'b0000;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        d_addr = a;
        #1;
        chk(name, {32'd0, d_rdata}, {32'd0, exp});
    endtask

    initial begin
        tbl[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[1] = '{32'h0000_0100, 32'h0000_5500, 4'b0010, 32'hDEAD_55EF, 32'hDEAD_55EF};
        tbl[2] = '{32'h0000_0104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[3] = '{32'h0000_0104, 32'hAABB_CCDD, 4'b1100, 32'hAABB_F00D, 32'hAABB_F00D};
        tbl[4] = '{32'h0000_0102, 32'h0000_0000, 4'b0000, 32'hDEAD_55EF, 32'hDEAD_55EF};
        tbl[5] = '{32'h0000_FFFC, 32'h0102_0304, 4'b1111, 32'h0102_0304, 32'h0102_0304};
        tbl[6] = '{32'h0001_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        tbl[7] = '{A_STAT,        32'h0000_0000, 4'b0000, 32'h0000_0002, 32'h0000_0000};
        tbl[8] = '{32'h8000_0020, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 32'h0000_0000};
        tbl[9] = '{A_CONS,        32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000};

        // Reset
        #2 reset_n = 1'b0;
        #1;
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_irq", {63'd0, timer_irq}, 64'd0);
        chk("rst_decode_err", {63'd0, decode_err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rd("rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        rd("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);

        // RAM / decode vector table
        for (int v = 0; v < 10; v++) begin
            d_addr  = tbl[v].addr;
            i_addr  = tbl[v].addr;
            d_wdata = tbl[v].wdata;
            d_wstrb = tbl[v].wstrb;
            if (tbl[v].wstrb != 4'b0000) begin
                cycle();
                d_wstrb = 4'b0000;
            end
            #1;
            chk($sformatf("tbl%0d_d_rdata", v), {32'd0, d_rdata}, {32'd0, tbl[v].exp_d});
            chk($sformatf("tbl%0d_i_data", v), {32'd0, i_data}, {32'd0, tbl[v].exp_i});
            chk($sformatf("tbl%0d_decode_err", v), {63'd0, decode_err}, 64'd0);
        end

        // Read during write returns old word
        d_addr  = 32'h0000_0100;
        i_addr  = 32'h0000_0100;
        d_wdata = 32'h1111_1111;
        d_wstrb = 4'b1111;
        #1;
        chk("rdw_old", {32'd0, d_rdata}, {32'd0, 32'hDEAD_55EF});
        cycle();
        d_wstrb = 4'b0000;
        #1;
        chk("rdw_new", {32'd0, d_rdata}, {32'd0, 32'h1111_1111});
        chk("rdw_new_i", {32'd0, i_data}, {32'd0, 32'h1111_1111});

        // FIFO overflow and ordered drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) store(A_CONS, 32'h41 + 32'(i), 4'b0001);
        rd("ovf_status", A_STAT, 32'h0000_0085);
        chk("ovf_head", {56'd0, tx_data}, 64'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), {63'd0, tx_valid}, 64'd1);
            chk($sformatf("drain%0d_data", i), {56'd0, tx_data}, 64'h41 + 64'(i));
            cycle();
        end
        chk("drained_valid", {63'd0, tx_valid}, 64'd0);
        rd("drained_status", A_STAT, 32'h0000_0006);
        store(A_STAT, 32'h0000_0004, 4'b0001);
        rd("ovf_cleared", A_STAT, 32'h0000_0002);

        // Full FIFO: push and pop together
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) store(A_CONS, 32'h30 + 32'(i), 4'b0001);
        rd("full_status", A_STAT, 32'h0000_0081);
        d_addr   = A_CONS;
        d_wdata  = 32'h0000_005A;
        d_wstrb  = 4'b0001;
        tx_ready = 1'b1;
        cycle();
        d_wstrb = 4'b0000;
        rd("pushpop_status", A_STAT, 32'h0000_0081);
        for (int j = 1; j < 8; j++) begin
            chk($sformatf("pp_drain%0d", j), {56'd0, tx_data}, 64'h30 + 64'(j));
            cycle();
        end
        chk("pp_last", {56'd0, tx_data}, 64'h5A);
        cycle();
        chk("pp_empty", {63'd0, tx_valid}, 64'd0);

        // Empty FIFO: push and pop together, no bypass
        d_addr  = A_CONS;
        d_wdata = 32'h0000_0077;
        d_wstrb = 4'b0001;
        #1;
        chk("nobypass_valid", {63'd0, tx_valid}, 64'd0);
        cycle();
        d_wstrb = 4'b0000;
        chk("nobypass_next_valid", {63'd0, tx_valid}, 64'd1);
        chk("nobypass_next_data", {56'd0, tx_data}, 64'h77);
        cycle();
        chk("nobypass_popped", {63'd0, tx_valid}, 64'd0);
        rd("nobypass_status", A_STAT, 32'h0000_0002);

        // mtime wrap
        store(A_MT_HI, 32'hFFFF_FFFF, 4'b1111);
        store(A_MT_LO, 32'hFFFF_FFFE, 4'b1111);
        rd("wrap0_lo", A_MT_LO, 32'hFFFF_FFFE);
        rd("wrap0_hi", A_MT_HI, 32'hFFFF_FFFF);
        chk("wrap0_irq", {63'd0, timer_irq}, 64'd0);
        cycle();
        rd("wrap1_lo", A_MT_LO, 32'hFFFF_FFFF);
        rd("wrap1_hi", A_MT_HI, 32'hFFFF_FFFF);
        chk("wrap1_irq_allones", {63'd0, timer_irq}, 64'd1);
        cycle();
        rd("wrap2_lo", A_MT_LO, 32'h0000_0000);
        rd("wrap2_hi", A_MT_HI, 32'h0000_0000);
        chk("wrap2_irq", {63'd0, timer_irq}, 64'd0);
        store(A_MT_LO, 32'h0000_AB00, 4'b0010);
        rd("mtime_byte_noinc", A_MT_LO, 32'h0000_AB00);

        // Compare fires five cycles out; MTIMECMP_HI all-ones drops it
        store(A_MT_HI, 32'h0000_0000, 4'b1111);
        store(A_MT_LO, 32'h0000_0000, 4'b1111);
        store(A_CMP_HI, 32'h0000_0000, 4'b1111);
        store(A_CMP_LO, 32'h0000_0006, 4'b1111);
        chk("cmp_set_irq", {63'd0, timer_irq}, 64'd0);
        repeat (3) cycle();
        rd("cmp_pre_lo", A_MT_LO, 32'h0000_0005);
        chk("cmp_pre_irq", {63'd0, timer_irq}, 64'd0);
        cycle();
        rd("cmp_hit_lo", A_MT_LO, 32'h0000_0006);
        chk("cmp_hit_irq", {63'd0, timer_irq}, 64'd1);
        store(A_CMP_HI, 32'hFFFF_FFFF, 4'b1111);
        chk("cmp_clear_irq", {63'd0, timer_irq}, 64'd0);

        // Unmapped accesses
        store(A_CMP_HI, 32'h0000_0000, 4'b1111);
        chk("irq_rearm", {63'd0, timer_irq}, 64'd1);
        d_addr = 32'h4000_0000;
        cycle();
        chk("unmapped_read_no_err", {63'd0, decode_err}, 64'd0);
        store(32'h4000_0000, 32'h1234_5678, 4'b1111);
        chk("decode_err_pulse", {63'd0, decode_err}, 64'd1);
        cycle();
        chk("decode_err_once", {63'd0, decode_err}, 64'd0);
        store(32'h4000_0100, 32'hBAD0_BAD0, 4'b1111);
        chk("decode_err_alias", {63'd0, decode_err}, 64'd1);
        store(32'h0001_0000, 32'hBAD0_BAD0, 4'b1111);
        chk("decode_err_ram_edge", {63'd0, decode_err}, 64'd1);
        cycle();
        chk("decode_err_low", {63'd0, decode_err}, 64'd0);
        rd("unmapped_ram_kept", 32'h0000_0100, 32'h1111_1111);
        rd("unmapped_top_kept", 32'h0000_FFFC, 32'h0102_0304);

        // Reset mid-drain
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(A_CONS, 32'h61 + 32'(i), 4'b0001);
        tx_ready = 1'b1;
        cycle();
        chk("middrain_head", {56'd0, tx_data}, 64'h62);
        reset_n = 1'b0;
        #1;
        chk("middrain_rst_valid", {63'd0, tx_valid}, 64'd0);
        chk("middrain_rst_irq", {63'd0, timer_irq}, 64'd0);
        rd("middrain_rst_status", A_STAT, 32'h0000_0002);
        cycle();
        reset_n = 1'b1;
        rd("postrst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        rd("postrst_ram_kept", 32'h0000_0100, 32'h1111_1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
